ahb_master_mc: RTL and testbench
================================

AHB_MASTER_MC -- requirements
Module: ahb_master_mc

Interface
REQ-001 Parameter NUM_CH, default 2: number of requester channels; legal range 1..8.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width; 32 or 64.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 ch_req  input  NUM_CH  per-channel request; held high with stable attributes until that channel's ch_done.
REQ-007 ch_addr  input  NUM_CH x ADDR_W  per-channel address.
REQ-008 ch_write  input  NUM_CH  per-channel direction: 1 = write.
REQ-009 ch_size  input  NUM_CH x 3  per-channel HSIZE encoding.
REQ-010 ch_wdata  input  NUM_CH x DATA_W  per-channel store data.
REQ-011 ch_done  output  NUM_CH  one-cycle completion pulse.
REQ-012 ch_err  output  NUM_CH  qualifies ch_done: the transfer ended with an ERROR response.
REQ-013 ch_rdata  output  DATA_W  hrdata, passed through combinationally; valid in the ch_done cycle.
REQ-014 haddr/hwrite/hsize/hburst/htrans  output  ADDR_W/1/3/3/2  AHB-Lite address-phase signals.
REQ-015 hwdata  output  DATA_W  registered write data.
REQ-016 hrdata/hready/hresp  input  DATA_W/1/1  AHB-Lite slave response.

Function
REQ-017 Address phase: eligible = ch_req & ~data-phase-owner mask; the arbiter picks one eligible channel.
  - Drives htrans NONSEQ, hburst SINGLE, plus the chosen channel's haddr, hwrite and hsize.
  - With no eligible channel: htrans IDLE and all other address outputs 0.
REQ-018 While hready=0, the address-phase grant is frozen and no re-arbitration occurs.
REQ-019 Address phase accepted (hready=1, htrans NONSEQ): the granted channel becomes the data-phase owner on the next edge.
  - On the same edge, hwdata <= ch_wdata[owner] for writes, 0 for reads.
REQ-020 Data-phase state machine states: D_IDLE, D_BUSY (owner id, write flag), D_ERR.
  - D_BUSY, hready=1, hresp=0: assert ch_done[owner] combinationally; go to D_IDLE, or to D_BUSY with the new owner if an address phase was accepted in the same cycle.
  - D_BUSY, hready=0, hresp=1: go to D_ERR; htrans forced IDLE this cycle.
  - D_ERR, hready=1: assert ch_done[owner] and ch_err[owner]; go to D_IDLE; htrans forced IDLE this cycle.
  - Any other D_ERR response (protocol violation): hold D_ERR.
REQ-021 A transfer cancelled by a forced IDLE is not lost: its channel stays pending and is re-arbitrated.
REQ-022 Pipelining: a different channel's address phase overlaps the current data phase.
  - The same channel cannot re-issue before its ch_done cycle has passed, giving a minimum 1-cycle gap.
REQ-023 Latency: an uncontended request with zero wait states gives ch_done 1 cycle after the address phase; each hready=0 cycle adds 1.
REQ-024 Simultaneous request rise and ch_done on the same channel: ch_done refers to the old transfer; the new request is not eligible until the next cycle.
REQ-025 ch_done and ch_err are never asserted for a channel that is not the data-phase owner.

Reset
REQ-026 rst=1 on an edge: data FSM D_IDLE, hwdata 0, frozen grant cleared, RR pointer 0.
REQ-027 While rst=1: htrans IDLE, all address outputs 0, ch_done and ch_err 0.
REQ-028 Reset mid-transfer abandons the transfer with no ch_done.

Configuration
REQ-029 Macro AHB_MASTER_RR_EN defined: round-robin arbitration.
  - Search starts at (last accepted grant + 1) mod NUM_CH.
  - The pointer updates only on address-phase acceptance.
REQ-030 Macro AHB_MASTER_RR_EN undefined: fixed priority, channel 0 highest.

Structure
REQ-031 The HTRANS constants (IDLE, BUSY, NONSEQ, SEQ), HBURST_SINGLE, the HSIZE encodings and the data-FSM state typedef reside in common_types_pkg.
REQ-032 Arbitration resides in a sub-module ahb_arbiter (NUM_CH-wide request in, one-hot grant out, advance strobe).
  - It contains the RR pointer under AHB_MASTER_RR_EN.

Verification
REQ-033 Single read: ch_req[0] at 0x0000_1000 with hrdata 0xDEAD_BEEF and zero waits -> one NONSEQ cycle, then ch_done[0]=1 with ch_rdata 0xDEAD_BEEF.
REQ-034 Write with 2 wait states: ch1 writes 0x1234_5678, size 2, to 0x2000_0004 -> hwdata 0x1234_5678 held for 3 data cycles; ch_done[1] on the third.
REQ-035 Contention: ch0 and ch1 requesting continuously.
  - RR build -> grants alternate 0,1,0,1.
  - Fixed build -> grant order 0,1,0,1 from the same-channel gap, never 1 twice in a row.
REQ-036 Error: slave returns ERROR to ch0 while ch1 is in the address phase.
  - htrans goes IDLE during both error cycles; ch_done[0] and ch_err[0] = 1.
  - ch1 is re-issued afterwards and completes with ch_err[1]=0.
REQ-037 Reset: rst asserted during a data phase with hready=0 -> next cycle htrans IDLE, no ch_done; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/common_types_pkg.sv
// Shared AHB-Lite encodings and the data-phase state type used by ahb_master_mc.
package common_types_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    typedef logic [1:0] dstate_t;
    localparam dstate_t D_IDLE = 2'd0;
    localparam dstate_t D_BUSY = 2'd1;
    localparam dstate_t D_ERR  = 2'd2;

endpackage

// File: rtl/ahb_arbiter.sv
// Channel arbiter for ahb_master_mc: round-robin when AHB_MASTER_RR_EN is defined,
// otherwise fixed priority with channel 0 highest.
module ahb_arbiter #(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic found;

`ifdef AHB_MASTER_RR_EN
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] gidx;

    // Search wraps from ptr, which always holds (last accepted grant + 1) mod NUM_CH.
    always_comb begin
        grant = '0;
        gidx  = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_CH);
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                gidx        = cand;
                found       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(gidx) == NUM_CH - 1) ? '0 : gidx + 1'b1;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst, advance};

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/ahb_master_mc.sv
// Multi-channel AHB-Lite master issuing SINGLE transfers with address/data pipelining.
// Define AHB_MASTER_RR_EN for round-robin arbitration; fixed priority otherwise.
module ahb_master_mc
    import common_types_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             ch_req,
    input  logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH-1:0]             ch_write,
    input  logic [NUM_CH-1:0][2:0]        ch_size,
    input  logic [NUM_CH-1:0][DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]             ch_done,
    output logic [NUM_CH-1:0]             ch_err,
    output logic [DATA_W-1:0]             ch_rdata,
    output logic [ADDR_W-1:0]             haddr,
    output logic                          hwrite,
    output logic [2:0]                    hsize,
    output logic [2:0]                    hburst,
    output logic [1:0]                    htrans,
    output logic [DATA_W-1:0]             hwdata,
    input  logic [DATA_W-1:0]             hrdata,
    input  logic                          hready,
    input  logic                          hresp
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    dstate_t           d_state;
    logic [IDX_W-1:0]  d_owner;
    logic [NUM_CH-1:0] frozen_grant;
    logic [NUM_CH-1:0] owner_mask;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] arb_req;
    logic [NUM_CH-1:0] grant;
    logic [IDX_W-1:0]  gidx;
    logic              force_idle;
    logic              addr_valid;
    logic              accept;
    logic              data_end;

    assign owner_mask = (d_state == D_IDLE) ? '0 : (NUM_CH'(1) << d_owner);
    assign eligible   = ch_req & ~owner_mask;
    // A stalled address phase presents only its own channel so grant and RR pointer stay put.
    assign arb_req    = (|frozen_grant) ? frozen_grant : eligible;

    ahb_arbiter #(.NUM_CH(NUM_CH)) u_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (accept),
        .grant   (grant)
    );

    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant[i]) gidx = IDX_W'(i);
        end
    end

    assign force_idle = (d_state == D_ERR) || (d_state == D_BUSY && !hready && hresp);
    assign addr_valid = !rst && !force_idle && (|grant);
    assign accept     = addr_valid && hready;
    assign data_end   = !rst && hready && (d_state != D_IDLE);

    assign htrans   = addr_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hburst   = HBURST_SINGLE;
    assign haddr    = addr_valid ? ch_addr[gidx] : '0;
    assign hwrite   = addr_valid && ch_write[gidx];
    assign hsize    = addr_valid ? ch_size[gidx] : '0;
    assign ch_done  = data_end ? owner_mask : '0;
    assign ch_err   = (data_end && d_state == D_ERR) ? owner_mask : '0;
    assign ch_rdata = hrdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_state      <= D_IDLE;
            d_owner      <= '0;
            hwdata       <= '0;
            frozen_grant <= '0;
        end else begin
            frozen_grant <= (addr_valid && !hready) ? grant : '0;
            if (accept) begin
                d_state <= D_BUSY;
                d_owner <= gidx;
                hwdata  <= ch_write[gidx] ? ch_wdata[gidx] : '0;
            end else begin
                case (d_state)
                    D_BUSY: begin
                        if (hready)     d_state <= D_IDLE;
                        else if (hresp) d_state <= D_ERR;
                    end
                    D_ERR: begin
                        if (hready) d_state <= D_IDLE;
                    end
                    default: d_state <= D_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ahb_master_mc.sv
// Self-checking bench for ahb_master_mc: directed scenarios then randomized traffic vs a transfer-level model.
module tb_ahb_master_mc;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          ch_req;
    logic [N-1:0][AW-1:0]  ch_addr;
    logic [N-1:0]          ch_write;
    logic [N-1:0][2:0]     ch_size;
    logic [N-1:0][DW-1:0]  ch_wdata;
    logic [N-1:0]          ch_done;
    logic [N-1:0]          ch_err;
    logic [DW-1:0]         ch_rdata;
    logic [AW-1:0]         haddr;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [1:0]            htrans;
    logic [DW-1:0]         hwdata;
    logic [DW-1:0]         hrdata;
    logic                  hready;
    logic                  hresp;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // transfer-level model state
    bit            m_dp_valid;
    bit            m_dp_err;
    int            m_dp_ch;
    bit            m_frz;
    int            m_frz_ch;
    int            m_last;
    logic [DW-1:0] m_hwdata;
    bit            done_seen [N];

    // per-cycle expectations and samples
    bit            e_valid;
    int            e_ch;
    bit            e_done;
    bit            e_err;
    logic [1:0]    s_htrans;
    logic [AW-1:0] s_haddr;
    logic [N-1:0]  s_done;
    logic [N-1:0]  s_err;
    logic [DW-1:0] s_hwdata;
    logic [DW-1:0] s_rdata;

    always #5 clk = ~clk;

    ahb_master_mc #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_req   (ch_req),
        .ch_addr  (ch_addr),
        .ch_write (ch_write),
        .ch_size  (ch_size),
        .ch_wdata (ch_wdata),
        .ch_done  (ch_done),
        .ch_err   (ch_err),
        .ch_rdata (ch_rdata),
        .haddr    (haddr),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hburst   (hburst),
        .htrans   (htrans),
        .hwdata   (hwdata),
        .hrdata   (hrdata),
        .hready   (hready),
        .hresp    (hresp)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_ch(input logic [N-1:0] elig);
        int p;
        p = -1;
`ifdef AHB_MASTER_RR_EN
        for (int k = 1; k <= N; k++) begin
            if (p < 0 && elig[(m_last + k) % N]) p = (m_last + k) % N;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (p < 0 && elig[k]) p = k;
        end
`endif
        return p;
    endfunction

    // One clock: check outputs at negedge against the model, advance the model at posedge.
    task automatic step();
        logic [N-1:0]  elig;
        bit            force_idle;
        logic [AW-1:0] x_addr;
        logic          x_write;
        logic [2:0]    x_size;
        logic [N-1:0]  x_done;
        @(negedge clk);
        e_ch = -1;
        if (rst) begin
            e_done = 1'b0;
            e_err  = 1'b0;
        end else begin
            e_done     = m_dp_valid && hready;
            e_err      = e_done && m_dp_err;
            force_idle = m_dp_valid && (m_dp_err || (!hready && hresp));
            elig       = ch_req;
            if (m_dp_valid) elig[m_dp_ch] = 1'b0;
            if (force_idle)  e_ch = -1;
            else if (m_frz)  e_ch = m_frz_ch;
            else             e_ch = pick_ch(elig);
        end
        e_valid = (e_ch >= 0);
        x_addr = '0; x_write = 1'b0; x_size = '0;
        if (e_valid) begin
            x_addr  = ch_addr[e_ch];
            x_write = ch_write[e_ch];
            x_size  = ch_size[e_ch];
        end
        x_done = e_done ? N'(1 << m_dp_ch) : '0;
        check("htrans", htrans, e_valid ? 2'b10 : 2'b00);
        check("haddr", haddr, x_addr);
        check("hwrite", hwrite, x_write);
        check("hsize", hsize, x_size);
        check("hburst", hburst, 3'b000);
        check("ch_done", ch_done, x_done);
        check("ch_err", ch_err, e_err ? x_done : '0);
        check("hwdata", hwdata, m_hwdata);
        if (e_done) check("ch_rdata", ch_rdata, hrdata);
        s_htrans = htrans; s_haddr = haddr; s_done = ch_done;
        s_err = ch_err; s_hwdata = hwdata; s_rdata = ch_rdata;
        @(posedge clk);
        for (int c = 0; c < N; c++) done_seen[c] = e_done && (m_dp_ch == c);
        if (rst) begin
            m_dp_valid = 1'b0;
            m_dp_err   = 1'b0;
            m_frz      = 1'b0;
            m_last     = N - 1;
            m_hwdata   = '0;
        end else begin
            m_frz    = e_valid && !hready;
            m_frz_ch = e_ch;
            if (m_dp_valid && !m_dp_err && !hready && hresp) m_dp_err = 1'b1;
            else if (e_done) m_dp_valid = 1'b0;
            if (e_valid && hready) begin
                m_dp_valid = 1'b1;
                m_dp_err   = 1'b0;
                m_dp_ch    = e_ch;
                m_last     = e_ch;
                m_hwdata   = ch_write[e_ch] ? ch_wdata[e_ch] : '0;
            end
        end
        #1;
    endtask

    task automatic new_attrs(input int c);
        ch_addr[c]  = $urandom;
        ch_write[c] = 1'($urandom_range(0, 1));
        ch_size[c]  = 3'($urandom_range(0, 2));
        ch_wdata[c] = $urandom;
    endtask

    task automatic drive_req();
        for (int c = 0; c < N; c++) begin
            if (ch_req[c] && done_seen[c]) begin
                if ($urandom_range(0, 1) == 0) ch_req[c] = 1'b0;
                else new_attrs(c);
            end else if (!ch_req[c] && $urandom_range(0, 9) < 4) begin
                ch_req[c] = 1'b1;
                new_attrs(c);
            end
        end
    endtask

    task automatic drive_slave();
        int unsigned r;
        hrdata = $urandom;
        hready = 1'b1;
        hresp  = 1'b0;
        if (m_dp_valid && m_dp_err) begin
            hresp = 1'b1;
        end else if (m_dp_valid) begin
            r = $urandom_range(0, 9);
            if (r >= 6) hready = 1'b0;
            if (r == 9) hresp  = 1'b1;
        end
    endtask

    initial begin
        int g;
        rst = 1'b1; ch_req = '0; ch_addr = '0; ch_write = '0; ch_size = '0; ch_wdata = '0;
        hrdata = '0; hready = 1'b1; hresp = 1'b0;
        m_dp_valid = 1'b0; m_dp_err = 1'b0; m_dp_ch = 0; m_frz = 1'b0; m_frz_ch = 0;
        m_last = N - 1; m_hwdata = '0;
        for (int c = 0; c < N; c++) done_seen[c] = 1'b0;

        step(); step();
        rst = 1'b0;
        step();
        check("rst_hwdata", s_hwdata, 0);

        // single read, zero waits
        ch_req[0] = 1'b1; ch_addr[0] = 32'h0000_1000; ch_write[0] = 1'b0; ch_size[0] = 3'd2;
        hrdata = 32'hDEAD_BEEF;
        step();
        check("rd_htrans", s_htrans, 2'b10);
        check("rd_haddr", s_haddr, 32'h0000_1000);
        step();
        check("rd_done", s_done, 3'b001);
        check("rd_rdata", s_rdata, 32'hDEAD_BEEF);
        ch_req[0] = 1'b0;

        // write with two wait states
        ch_req[1] = 1'b1; ch_addr[1] = 32'h2000_0004; ch_write[1] = 1'b1; ch_size[1] = 3'd2;
        ch_wdata[1] = 32'h1234_5678;
        step();
        check("wr_haddr", s_haddr, 32'h2000_0004);
        hready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) hready = 1'b1;
            step();
            check("wr_hwdata", s_hwdata, 32'h1234_5678);
            check("wr_done", s_done, (k == 2) ? 3'b010 : 3'b000);
        end
        ch_req[1] = 1'b0;

        // contention: grants alternate 0,1,0,1
        ch_addr[0] = 32'hA0; ch_write[0] = 1'b0;
        ch_addr[1] = 32'hB0; ch_write[1] = 1'b0;
        ch_req[0] = 1'b1; ch_req[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            g = (s_haddr == 32'hB0) ? 1 : (s_haddr == 32'hA0) ? 0 : 7;
            check("cont_grant", g, k % 2);
        end
        ch_req[0] = 1'b0;
        step();
        check("cont_tail_done", s_done, 3'b010);
        ch_req[1] = 1'b0;

        // error on ch0 while ch1 is in its address phase
        ch_req[0] = 1'b1; ch_addr[0] = 32'hC0;
        step();
        ch_req[1] = 1'b1; ch_addr[1] = 32'hD0;
        hready = 1'b0; hresp = 1'b1;
        step();
        check("err1_htrans", s_htrans, 2'b00);
        hready = 1'b1;
        step();
        check("err2_htrans", s_htrans, 2'b00);
        check("err2_done", s_done, 3'b001);
        check("err2_err", s_err, 3'b001);
        ch_req[0] = 1'b0; hresp = 1'b0;
        step();
        check("reissue_htrans", s_htrans, 2'b10);
        check("reissue_haddr", s_haddr, 32'hD0);
        step();
        check("reissue_done", s_done, 3'b010);
        check("reissue_err", s_err, 3'b000);
        ch_req[1] = 1'b0;

        // reset during a stalled data phase
        ch_req[0] = 1'b1; ch_addr[0] = 32'hE0;
        step();
        rst = 1'b1; hready = 1'b0;
        step();
        check("rstmid_done", s_done, 3'b000);
        check("rstmid_htrans", s_htrans, 2'b00);
        rst = 1'b0; ch_req[0] = 1'b0; hready = 1'b1;
        step();
        check("postrst_htrans", s_htrans, 2'b00);
        check("postrst_done", s_done, 3'b000);
        ch_req[1] = 1'b1; ch_addr[1] = 32'hF0; ch_write[1] = 1'b0;
        step();
        check("fresh_haddr", s_haddr, 32'hF0);
        step();
        check("fresh_done", s_done, 3'b010);
        ch_req[1] = 1'b0;
        step();

        // randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            drive_slave();
            drive_req();
            rst = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
